// File: rtl/bram_readback_checker.sv
// ============================================================================
// Module      : bram_readback_checker
// Description : Sweeps every BRAM address once and checks each word against
//               BASE + address, reporting mismatch count and first failure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_readback_checker #(
  parameter int          ADDR_W       = 4,
  parameter int          DATA_W       = 16,
  parameter int unsigned BASE         = 32'h1000,
  parameter int          READ_LATENCY = 1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              start,
  input  logic              abort,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] C_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] C_BASE  = DATA_W'(BASE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [READ_LATENCY-1:0] r_vld;
  logic [ADDR_W-1:0]     r_tag [READ_LATENCY];
  logic [ADDR_W:0]       r_err;
  logic [ADDR_W-1:0]     r_first_addr;
  logic [DATA_W-1:0]     r_first_data;
  logic                  r_pass;

  logic                  w_start_acc;
  logic                  w_running;
  logic                  w_flush;
  logic                  w_cmp;
  logic                  w_mis;
  logic                  w_last_cmp;
  logic [ADDR_W:0]       w_err_nxt;

  assign w_running   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_start_acc = (r_state == S_IDLE) && start && !abort;
  assign w_flush     = w_running && abort;

  // Reads still in flight when a pass is aborted are discarded, not compared.
  assign w_cmp      = r_vld[READ_LATENCY-1] && !abort;
  assign w_mis      = w_cmp && (douta != (C_BASE + DATA_W'(r_tag[READ_LATENCY-1])));
  assign w_last_cmp = r_vld[READ_LATENCY-1] && (r_tag[READ_LATENCY-1] == C_LAST);
  assign w_err_nxt  = (w_mis && (r_err != C_DEPTH)) ? r_err + 1'b1 : r_err;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ena         = 1'b0;
    addra       = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        ena   = 1'b1;
        addra = r_addr;
        busy  = 1'b1;
        if (abort)                 w_state_nxt = S_IDLE;
        else if (r_addr == C_LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort)           w_state_nxt = S_IDLE;
        else if (w_last_cmp) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_addr <= '0;
    end else if ((r_state == S_ISSUE) && !abort) begin
      r_addr <= r_addr + 1'b1;
    end else begin
      r_addr <= '0;
    end
  end

  // Each stage carries the address whose data arrives READ_LATENCY cycles later.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_tag[i] <= '0;
    end else if (w_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= (r_state == S_ISSUE);
      r_tag[0] <= r_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      r_err        <= '0;
      r_first_addr <= '0;
      r_first_data <= '0;
      r_pass       <= 1'b0;
    end else if (w_start_acc) begin
      r_err        <= '0;
      r_first_addr <= '0;
      r_first_data <= '0;
      r_pass       <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      if (w_mis && (r_err == '0)) begin
        r_first_addr <= r_tag[READ_LATENCY-1];
        r_first_data <= douta;
      end
      if (w_flush) begin
        r_pass <= 1'b0;
      end else if ((r_state == S_DRAIN) && w_last_cmp) begin
        r_pass <= (w_err_nxt == '0);
      end
    end
  end

  assign wea            = 1'b0;
  assign dina           = '0;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_first_addr;
  assign first_err_data = r_first_data;

endmodule

`default_nettype wire
